// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one data-bus access per EX/MEM request, stalls the
// pipeline until it completes, then presents formatted load data and exception status.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_mem_read,
  input  logic        ex_mem_mem_write,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_mem_write_data,
  input  logic [2:0]  ex_mem_funct3,
  output logic        mem_stall,
  output logic [31:0] mem_load_data,
  output logic        mem_done,
  output logic        mem_exc,
  output logic [1:0]  mem_exc_cause,
  output logic        dbus_req_valid,
  input  logic        dbus_req_ready,
  output logic        dbus_req_we,
  output logic [31:0] dbus_req_addr,
  output logic [31:0] dbus_req_wdata,
  output logic [3:0]  dbus_req_be,
  input  logic        dbus_rsp_valid,
  input  logic [31:0] dbus_rsp_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);
  localparam logic [1:0]  CauseMisaligned = 2'b01;
  localparam logic [1:0]  CauseTimeout    = 2'b10;
  localparam logic [1:0]  CauseIllegal    = 2'b11;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;

  logic        req;
  logic        is_store;
  logic [1:0]  offset;
  logic        size_byte;
  logic        size_half;
  logic        size_word;
  logic        size_legal;
  logic        misaligned;
  logic        timeout_hit;
  logic [3:0]  be_dec;
  logic [31:0] wdata_dec;

  assign req      = ex_mem_mem_read | ex_mem_mem_write;
  assign is_store = ex_mem_mem_write;
  assign offset   = ex_mem_alu_result[1:0];

  // Unsigned load sizes have no store counterpart.
  always_comb begin
    size_byte = 1'b0;
    size_half = 1'b0;
    size_word = 1'b0;
    case (ex_mem_funct3)
      3'b000:  size_byte = 1'b1;
      3'b001:  size_half = 1'b1;
      3'b010:  size_word = 1'b1;
      3'b100:  size_byte = ~is_store;
      3'b101:  size_half = ~is_store;
      default: ;
    endcase
  end

  assign size_legal = size_byte | size_half | size_word;
  assign misaligned = (size_half & offset[0]) | (size_word & (offset != 2'b00));

  always_comb begin
    be_dec    = 4'b1111;
    wdata_dec = ex_mem_mem_write_data;
    if (size_byte) begin
      be_dec    = 4'b0001 << offset;
      wdata_dec = {4{ex_mem_mem_write_data[7:0]}};
    end else if (size_half) begin
      be_dec    = offset[1] ? 4'b1100 : 4'b0011;
      wdata_dec = {2{ex_mem_mem_write_data[15:0]}};
    end
  end

  assign timeout_hit = (cnt_q == TimeoutLast);

  always_comb begin
    unique case (state_q)
      StIdle:  mem_stall = req;
      StReq:   mem_stall = 1'b1;
      StWait:  mem_stall = 1'b1;
      StDone:  mem_stall = 1'b0;
      default: mem_stall = 1'b0;
    endcase
  end

  function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                           input logic [1:0]  off,
                                           input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  fmt_load = {{24{sh[7]}}, sh[7:0]};
      3'b001:  fmt_load = {{16{sh[15]}}, sh[15:0]};
      3'b100:  fmt_load = {24'd0, sh[7:0]};
      3'b101:  fmt_load = {16'd0, sh[15:0]};
      default: fmt_load = sh;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      funct3_q       <= '0;
      offset_q       <= '0;
      mem_load_data  <= '0;
      mem_done       <= 1'b0;
      mem_exc        <= 1'b0;
      mem_exc_cause  <= '0;
      dbus_req_valid <= 1'b0;
      dbus_req_we    <= 1'b0;
      dbus_req_addr  <= '0;
      dbus_req_wdata <= '0;
      dbus_req_be    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            if (!size_legal || misaligned) begin
              mem_done      <= 1'b1;
              mem_exc       <= 1'b1;
              mem_exc_cause <= size_legal ? CauseMisaligned : CauseIllegal;
              mem_load_data <= '0;
              state_q       <= StDone;
            end else begin
              dbus_req_valid <= 1'b1;
              dbus_req_we    <= is_store;
              dbus_req_addr  <= {ex_mem_alu_result[31:2], 2'b00};
              dbus_req_be    <= be_dec;
              dbus_req_wdata <= wdata_dec;
              funct3_q       <= ex_mem_funct3;
              offset_q       <= offset;
              cnt_q          <= '0;
              state_q        <= StReq;
            end
          end
        end
        StReq: begin
          if (timeout_hit) begin
            dbus_req_valid <= 1'b0;
            mem_done       <= 1'b1;
            mem_exc        <= 1'b1;
            mem_exc_cause  <= CauseTimeout;
            mem_load_data  <= '0;
            state_q        <= StDone;
          end else begin
            cnt_q <= cnt_q + 16'd1;
            if (dbus_req_ready) begin
              dbus_req_valid <= 1'b0;
              state_q        <= StWait;
            end
          end
        end
        StWait: begin
          // A response on the final budgeted cycle still counts as completion.
          if (dbus_rsp_valid) begin
            mem_load_data <= dbus_req_we ? 32'd0 : fmt_load(funct3_q, offset_q, dbus_rsp_rdata);
            mem_done      <= 1'b1;
            mem_exc       <= 1'b0;
            mem_exc_cause <= '0;
            state_q       <= StDone;
          end else if (timeout_hit) begin
            mem_done      <= 1'b1;
            mem_exc       <= 1'b1;
            mem_exc_cause <= CauseTimeout;
            mem_load_data <= '0;
            state_q       <= StDone;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StDone: begin
          mem_done      <= 1'b0;
          mem_exc       <= 1'b0;
          mem_exc_cause <= '0;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed scenarios plus randomized accesses checked against
// an arithmetic reference model of sizes, lanes and load extension.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdat = '0;
  logic [2:0]  f3 = '0;
  logic        ready = 1'b0, rsp_valid = 1'b0;
  logic [31:0] rdata = '0;

  logic        stall, done, exc, vld, we;
  logic [31:0] ldata, raddr, rwdata;
  logic [1:0]  cause;
  logic [3:0]  be;

  logic        t_stall, t_done, t_exc, t_vld, t_we;
  logic [31:0] t_ldata, t_raddr, t_rwdata;
  logic [1:0]  t_cause;
  logic [3:0]  t_be;

  int ncmp = 0;
  int nfail = 0;
  logic [31:0] exp_ld = '0;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst),
    .ex_mem_mem_read(rd), .ex_mem_mem_write(wr), .ex_mem_alu_result(addr),
    .ex_mem_mem_write_data(wdat), .ex_mem_funct3(f3),
    .mem_stall(stall), .mem_load_data(ldata), .mem_done(done), .mem_exc(exc),
    .mem_exc_cause(cause), .dbus_req_valid(vld), .dbus_req_ready(ready),
    .dbus_req_we(we), .dbus_req_addr(raddr), .dbus_req_wdata(rwdata), .dbus_req_be(be),
    .dbus_rsp_valid(rsp_valid), .dbus_rsp_rdata(rdata)
  );

  mem_stage_lsu #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst),
    .ex_mem_mem_read(rd), .ex_mem_mem_write(wr), .ex_mem_alu_result(addr),
    .ex_mem_mem_write_data(wdat), .ex_mem_funct3(f3),
    .mem_stall(t_stall), .mem_load_data(t_ldata), .mem_done(t_done), .mem_exc(t_exc),
    .mem_exc_cause(t_cause), .dbus_req_valid(t_vld), .dbus_req_ready(ready),
    .dbus_req_we(t_we), .dbus_req_addr(t_raddr), .dbus_req_wdata(t_rwdata),
    .dbus_req_be(t_be), .dbus_rsp_valid(rsp_valid), .dbus_rsp_rdata(rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Access size in bytes; 0 marks an illegal funct3 for this direction.
  function automatic int size_of(input bit st, input logic [2:0] f);
    case (f)
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 4;
      3'd4: return st ? 0 : 1;
      3'd5: return st ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [1:0] ref_cause(input bit st, input logic [2:0] f,
                                           input logic [31:0] a);
    int n;
    n = size_of(st, f);
    if (n == 0) return 2'b11;
    if ((a % n) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] ref_be(input int n, input logic [31:0] a);
    logic [7:0] m;
    m = ((8'd1 << n) - 8'd1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input int n, input logic [31:0] d);
    logic [31:0] m, r;
    m = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    r = '0;
    for (int i = 0; i < 4; i += n) r = r | ((d & m) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] rdv);
    int n;
    logic [63:0] v, m;
    n = size_of(1'b0, f);
    m = (64'd1 << (8 * n)) - 64'd1;
    v = ({32'd0, rdv} >> (8 * (a % 4))) & m;
    if (!f[2] && n < 4 && v[8*n-1]) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  // Runs one EX/MEM request on the main DUT, starting and ending in IDLE.
  task automatic access(input string tag, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f, input int rdy_dly,
                        input int rsp_dly, input logic [31:0] rdv, input bit junk,
                        output logic [31:0] got_ld, output logic [1:0] got_cause);
    logic [1:0] c;
    int n;
    c = ref_cause(w, f, a);
    n = size_of(w, f);
    rd = r; wr = w; addr = a; wdat = d; f3 = f; ready = 1'b0; rsp_valid = 1'b0; rdata = '0;
    #1;
    chk({tag, " idle stall"}, stall, 1'b1);
    chk({tag, " idle valid"}, vld, 1'b0);
    cyc();
    if (c != 2'b00) begin
      #1;
      chk({tag, " exc done"}, done, 1'b1);
      chk({tag, " exc flag"}, exc, 1'b1);
      chk({tag, " exc cause"}, cause, c);
      chk({tag, " exc ldata"}, ldata, 32'd0);
      chk({tag, " exc valid"}, vld, 1'b0);
      chk({tag, " exc stall"}, stall, 1'b0);
      exp_ld = '0;
    end else begin
      for (int i = 0; i <= rdy_dly; i++) begin
        if (i == rdy_dly) begin
          ready = 1'b1; rsp_valid = junk; rdata = ~rdv;
        end
        #1;
        chk({tag, " req valid"}, vld, 1'b1);
        chk({tag, " req we"}, we, w);
        chk({tag, " req addr"}, raddr, a - (a % 4));
        chk({tag, " req be"}, be, ref_be(n, a));
        chk({tag, " req wdata"}, rwdata, ref_wdata(n, d));
        chk({tag, " req stall"}, stall, 1'b1);
        chk({tag, " req done"}, done, 1'b0);
        cyc();
      end
      ready = 1'b0; rsp_valid = 1'b0;
      for (int i = 0; i <= rsp_dly; i++) begin
        if (i == rsp_dly) begin
          rsp_valid = 1'b1; rdata = rdv;
        end
        #1;
        chk({tag, " wait valid"}, vld, 1'b0);
        chk({tag, " wait stall"}, stall, 1'b1);
        chk({tag, " wait done"}, done, 1'b0);
        cyc();
      end
      rsp_valid = 1'b0;
      exp_ld = w ? 32'd0 : ref_load(f, a, rdv);
      #1;
      chk({tag, " done"}, done, 1'b1);
      chk({tag, " done exc"}, exc, 1'b0);
      chk({tag, " done cause"}, cause, 2'b00);
      chk({tag, " done stall"}, stall, 1'b0);
      chk({tag, " ldata"}, ldata, exp_ld);
    end
    got_ld = ldata;
    got_cause = cause;
    rd = 1'b0; wr = 1'b0;
    cyc();
    #1;
    chk({tag, " after done"}, done, 1'b0);
    chk({tag, " after exc"}, exc, 1'b0);
    chk({tag, " ldata held"}, ldata, exp_ld);
    chk({tag, " after stall"}, stall, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " ldata"}, ldata, 32'd0);
    chk({tag, " done"}, done, 1'b0);
    chk({tag, " exc"}, exc, 1'b0);
    chk({tag, " cause"}, cause, 2'b00);
    chk({tag, " valid"}, vld, 1'b0);
    chk({tag, " we"}, we, 1'b0);
    chk({tag, " addr"}, raddr, 32'd0);
    chk({tag, " wdata"}, rwdata, 32'd0);
    chk({tag, " be"}, be, 4'd0);
    chk({tag, " stall"}, stall, 1'b0);
  endtask

  initial begin
    logic [31:0] ld;
    logic [1:0]  cs;

    // Reset state
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    check_reset_state("reset");
    chk("reset t valid", t_vld, 1'b0);
    chk("reset t done", t_done, 1'b0);
    cyc();

    // 1: LW, ready immediately, response next cycle
    access("t1 lw", 1, 0, 32'h100, 32'h0, 3'b010, 0, 0, 32'hDEADBEEF, 0, ld, cs);
    chk("t1 lw value", ld, 32'hDEADBEEF);

    // 2: byte/half loads from a non-zero lane
    access("t2 lb", 1, 0, 32'h103, 32'h0, 3'b000, 0, 0, 32'h80FF7F01, 1, ld, cs);
    chk("t2 lb value", ld, 32'hFFFFFF80);
    access("t2 lbu", 1, 0, 32'h103, 32'h0, 3'b100, 0, 0, 32'h80FF7F01, 0, ld, cs);
    chk("t2 lbu value", ld, 32'h00000080);
    access("t2 lh", 1, 0, 32'h102, 32'h0, 3'b001, 0, 0, 32'h80FF7F01, 0, ld, cs);
    chk("t2 lh value", ld, 32'hFFFF80FF);

    // 3: SH with a slow bus (ready low for 5 cycles)
    access("t3 sh", 0, 1, 32'h202, 32'h1234ABCD, 3'b001, 5, 0, 32'h0, 0, ld, cs);
    chk("t3 sh ldata", ld, 32'd0);

    // 4: misaligned and illegal size
    access("t4 mis", 1, 0, 32'h101, 32'h0, 3'b010, 0, 0, 32'h0, 0, ld, cs);
    chk("t4 mis cause", cs, 2'b01);
    access("t4 ill", 1, 0, 32'h100, 32'h0, 3'b011, 0, 0, 32'h0, 0, ld, cs);
    chk("t4 ill cause", cs, 2'b11);
    access("t4 sbu", 0, 1, 32'h100, 32'h55, 3'b100, 0, 0, 32'h0, 0, ld, cs);
    chk("t4 sbu cause", cs, 2'b11);

    // Randomized accesses
    for (int k = 0; k < 40; k++) begin
      int sel;
      bit r, w;
      logic [31:0] a;
      logic [2:0] f;
      sel = $urandom_range(0, 3);
      r = (sel != 1);
      w = (sel == 1 || sel == 2);
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) begin
        int pick;
        pick = $urandom_range(0, 4);
        f = (pick < 3) ? 3'(pick) : 3'(pick + 1);
      end else begin
        f = 3'($urandom_range(0, 7));
      end
      access($sformatf("rnd%0d", k), r, w, a, $urandom, f, $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)), ld, cs);
    end

    // 5: timeout on the TIMEOUT=4 instance
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_ld = '0;
    access("t5 warm", 1, 0, 32'h40, 32'h0, 3'b010, 0, 0, 32'h0BADCAFE, 0, ld, cs);
    chk("t5 warm t ldata", t_ldata, 32'h0BADCAFE);
    rd = 1'b1; wr = 1'b0; addr = 32'h80; f3 = 3'b010; ready = 1'b1; rsp_valid = 1'b0;
    #1;
    chk("t5 idle stall", t_stall, 1'b1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t5 busy%0d done", i), t_done, 1'b0);
      chk($sformatf("t5 busy%0d stall", i), t_stall, 1'b1);
      cyc();
    end
    #1;
    chk("t5 to done", t_done, 1'b1);
    chk("t5 to exc", t_exc, 1'b1);
    chk("t5 to cause", t_cause, 2'b10);
    chk("t5 to ldata", t_ldata, 32'd0);
    chk("t5 to valid", t_vld, 1'b0);
    chk("t5 to stall", t_stall, 1'b0);
    rd = 1'b0; ready = 1'b0;
    cyc();
    rsp_valid = 1'b1; rdata = 32'h12345678;
    #1;
    chk("t5 late done", t_done, 1'b0);
    cyc();
    rsp_valid = 1'b0;
    #1;
    chk("t5 late done2", t_done, 1'b0);
    chk("t5 late ldata", t_ldata, 32'd0);
    chk("t5 late stall", t_stall, 1'b0);
    chk("t5 late valid", t_vld, 1'b0);

    // 6: reset while waiting for a response
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    access("t6 pre", 1, 0, 32'h10, 32'h0, 3'b010, 0, 0, 32'hCAFEF00D, 0, ld, cs);
    rd = 1'b1; wr = 1'b0; addr = 32'h20; f3 = 3'b010; ready = 1'b1;
    cyc();
    cyc();
    ready = 1'b0;
    #1;
    chk("t6 in wait stall", stall, 1'b1);
    rst = 1'b1; rd = 1'b0;
    cyc();
    rst = 1'b0;
    #1;
    check_reset_state("t6 rst");
    exp_ld = '0;
    rsp_valid = 1'b1; rdata = 32'hFFFF0000;
    cyc();
    rsp_valid = 1'b0;
    #1;
    chk("t6 stray done", done, 1'b0);
    chk("t6 stray ldata", ldata, 32'd0);
    cyc();
    #1;
    chk("t6 stray done2", done, 1'b0);
    access("t6 post", 1, 0, 32'h24, 32'h0, 3'b010, 0, 1, 32'h600DD00D, 0, ld, cs);
    chk("t6 post value", ld, 32'h600DD00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
